// File: rtl/reorder_buffer.sv
// Circular N_WAY-wide reorder buffer feeding retired Told tags to the free list.
// Optional squash port and logic enabled by defining ROB_FLUSH_EN.
module reorder_buffer #(
    parameter int N_WAY    = 2,
    parameter int N_ROB    = 16,
    parameter int TAG_BITS = 6,
    parameter int IDX_BITS = $clog2(N_ROB)
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [$clog2(N_WAY):0]             dispatch_num,
    input  logic [N_WAY-1:0][TAG_BITS-1:0]     dispatch_t,
    input  logic [N_WAY-1:0][TAG_BITS-1:0]     dispatch_told,
    input  logic [N_WAY-1:0][4:0]              dispatch_arch,
    output logic [N_WAY-1:0][IDX_BITS-1:0]     rob_idx_out,
    output logic [$clog2(N_ROB):0]             rob_space,
    input  logic [N_WAY-1:0]                   complete_valid,
    input  logic [N_WAY-1:0][IDX_BITS-1:0]     complete_idx,
    output logic [$clog2(N_WAY):0]             retire_num,
    output logic [N_WAY-1:0][TAG_BITS-1:0]     rob_told,
    output logic [N_WAY-1:0][TAG_BITS-1:0]     retire_t,
    output logic [N_WAY-1:0][4:0]              retire_arch
`ifdef ROB_FLUSH_EN
    ,
    input  logic                               flush
`endif
);

    localparam int NW_BITS  = $clog2(N_WAY) + 1;
    localparam int CNT_BITS = $clog2(N_ROB) + 1;

    logic [IDX_BITS-1:0] head_q, head_d;
    logic [IDX_BITS-1:0] tail_q, tail_d;
    logic [CNT_BITS-1:0] count_q, count_d;

    logic [N_ROB-1:0]    valid_q;
    logic [N_ROB-1:0]    done_q;
    logic [TAG_BITS-1:0] t_q    [N_ROB];
    logic [TAG_BITS-1:0] told_q [N_ROB];
    logic [4:0]          arch_q [N_ROB];

    logic [CNT_BITS-1:0] accept;
    logic [IDX_BITS-1:0] disp_idx [N_WAY];
    logic [IDX_BITS-1:0] scan_idx [N_WAY];
    logic                blocked;
    logic                squash;

`ifdef ROB_FLUSH_EN
    assign squash = flush;
`else
    assign squash = 1'b0;
`endif

    assign rob_space = CNT_BITS'(N_ROB) - count_q;

    // Clamp the dispatch request to lane count and to free entries.
    always_comb begin
        accept = CNT_BITS'(dispatch_num);
        if (accept > CNT_BITS'(N_WAY)) accept = CNT_BITS'(N_WAY);
        if (accept > rob_space) accept = rob_space;
    end

    // Entry indices for dispatch lanes (from tail) and retire scan (from head).
    always_comb begin
        for (int i = 0; i < N_WAY; i++) begin
            disp_idx[i]    = tail_q + IDX_BITS'(i);
            scan_idx[i]    = head_q + IDX_BITS'(i);
            rob_idx_out[i] = disp_idx[i];
        end
    end

    // In-order retire scan: stop at the first entry not both valid and done.
    always_comb begin
        retire_num  = '0;
        rob_told    = '0;
        retire_t    = '0;
        retire_arch = '0;
        blocked     = 1'b0;
        for (int k = 0; k < N_WAY; k++) begin
            if (!blocked && valid_q[scan_idx[k]] && done_q[scan_idx[k]]) begin
                retire_num     = retire_num + NW_BITS'(1);
                rob_told[k]    = told_q[scan_idx[k]];
                retire_t[k]    = t_q[scan_idx[k]];
                retire_arch[k] = arch_q[scan_idx[k]];
            end else begin
                blocked = 1'b1;
            end
        end
        if (squash) begin
            retire_num  = '0;
            rob_told    = '0;
            retire_t    = '0;
            retire_arch = '0;
        end
    end

    // Pointer and occupancy next state.
    always_comb begin
        head_d  = head_q + IDX_BITS'(retire_num);
        tail_d  = tail_q + IDX_BITS'(accept);
        count_d = count_q + accept - CNT_BITS'(retire_num);
        if (squash) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // State update: completion, then retire clear, then dispatch write.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int c = 0; c < N_WAY; c++) begin
                if (complete_valid[c] && valid_q[complete_idx[c]])
                    done_q[complete_idx[c]] <= 1'b1;
            end
            for (int k = 0; k < N_WAY; k++) begin
                if (NW_BITS'(k) < retire_num) begin
                    valid_q[scan_idx[k]] <= 1'b0;
                    done_q[scan_idx[k]]  <= 1'b0;
                end
            end
            for (int i = 0; i < N_WAY; i++) begin
                if (CNT_BITS'(i) < accept) begin
                    valid_q[disp_idx[i]] <= 1'b1;
                    done_q[disp_idx[i]]  <= 1'b0;
                    t_q[disp_idx[i]]     <= dispatch_t[i];
                    told_q[disp_idx[i]]  <= dispatch_told[i];
                    arch_q[disp_idx[i]]  <= dispatch_arch[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Scoreboard bench for reorder_buffer: queue-based program-order model.
// Exercises the flush path too when ROB_FLUSH_EN is defined.
module tb_reorder_buffer;

    localparam int NW = 2;
    localparam int NR = 16;
    localparam int TB = 6;
    localparam int IB = 4;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [1:0]             dispatch_num;
    logic [NW-1:0][TB-1:0]  dispatch_t;
    logic [NW-1:0][TB-1:0]  dispatch_told;
    logic [NW-1:0][4:0]     dispatch_arch;
    logic [NW-1:0][IB-1:0]  rob_idx_out;
    logic [IB:0]            rob_space;
    logic [NW-1:0]          complete_valid;
    logic [NW-1:0][IB-1:0]  complete_idx;
    logic [1:0]             retire_num;
    logic [NW-1:0][TB-1:0]  rob_told;
    logic [NW-1:0][TB-1:0]  retire_t;
    logic [NW-1:0][4:0]     retire_arch;
`ifdef ROB_FLUSH_EN
    logic                   flush;
`endif

    reorder_buffer dut (
        .clock          (clock),
        .reset          (reset),
        .dispatch_num   (dispatch_num),
        .dispatch_t     (dispatch_t),
        .dispatch_told  (dispatch_told),
        .dispatch_arch  (dispatch_arch),
        .rob_idx_out    (rob_idx_out),
        .rob_space      (rob_space),
        .complete_valid (complete_valid),
        .complete_idx   (complete_idx),
        .retire_num     (retire_num),
        .rob_told       (rob_told),
        .retire_t       (retire_t),
        .retire_arch    (retire_arch)
`ifdef ROB_FLUSH_EN
        ,
        .flush          (flush)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int idx;
        int t;
        int told;
        int arch;
        bit done;
    } ent_t;

    ent_t mq[$];
    ent_t sb[$];
    int   mtail = 0;
    int   lt[NW];
    int   lo[NW];
    int   la[NW];
    int   n_checks = 0;
    int   n_pass = 0;
    bit   active = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int exp_retire();
        int n = 0;
        while (n < NW && n < mq.size() && mq[n].done) n++;
        return n;
    endfunction

    task automatic rand_lanes();
        for (int i = 0; i < NW; i++) begin
            lt[i] = int'($urandom_range(1, 48));
            lo[i] = int'($urandom_range(0, 48));
            la[i] = int'($urandom_range(0, 31));
        end
    endtask

    // Indices of the two oldest not-yet-completed entries.
    task automatic comp_oldest(output bit [1:0] cv, output int c0, output int c1);
        int n = 0;
        cv = 2'b00;
        c0 = 0;
        c1 = 0;
        foreach (mq[j]) begin
            if (!mq[j].done && n < 2) begin
                if (n == 0) c0 = mq[j].idx;
                else c1 = mq[j].idx;
                cv[n] = 1'b1;
                n++;
            end
        end
    endtask

    task automatic cycle(input int dn, input bit [1:0] cv,
                         input int c0, input int c1, input bit fl = 1'b0);
        int er;
        int space;
        int acc;
        int ci;
        ent_t e;
        dispatch_num = 2'(dn);
        for (int i = 0; i < NW; i++) begin
            dispatch_t[i]    = TB'(lt[i]);
            dispatch_told[i] = TB'(lo[i]);
            dispatch_arch[i] = 5'(la[i]);
        end
        complete_valid  = cv;
        complete_idx[0] = IB'(c0);
        complete_idx[1] = IB'(c1);
`ifdef ROB_FLUSH_EN
        flush = fl;
`endif
        #1;
        er    = fl ? 0 : exp_retire();
        space = NR - mq.size();
        chk("rob_space", int'(rob_space), space);
        chk("rob_idx0", int'(rob_idx_out[0]), mtail);
        chk("rob_idx1", int'(rob_idx_out[1]), (mtail + 1) % NR);
        chk("retire_num", int'(retire_num), er);
        if (fl) begin
            mq.delete();
            sb.delete();
            mtail = 0;
        end else begin
            acc = (dn > space) ? space : dn;
            if (dn > space)
                $display("NOTE protocol violation: dispatch_num %0d > rob_space %0d",
                         dn, space);
            repeat (er) void'(mq.pop_front());
            for (int c = 0; c < NW; c++) begin
                ci = (c == 0) ? c0 : c1;
                if (cv[c]) foreach (mq[j]) if (mq[j].idx == ci) mq[j].done = 1'b1;
            end
            for (int i = 0; i < acc; i++) begin
                e.idx  = (mtail + i) % NR;
                e.t    = lt[i];
                e.told = lo[i];
                e.arch = la[i];
                e.done = 1'b0;
                mq.push_back(e);
                sb.push_back(e);
            end
            mtail = (mtail + acc) % NR;
        end
        @(negedge clock);
    endtask

    // Monitor: pop one expected record per retiring lane, in program order.
    initial begin
        ent_t e;
        forever begin
            @(negedge clock);
            #2;
            if (active) begin
                for (int k = 0; k < NW; k++) begin
                    if (k < int'(retire_num)) begin
                        if (sb.size() == 0) begin
                            chk("sb_underflow", 1, 0);
                        end else begin
                            e = sb.pop_front();
                            chk("rob_told", int'(rob_told[k]), e.told);
                            chk("retire_t", int'(retire_t[k]), e.t);
                            chk("retire_arch", int'(retire_arch[k]), e.arch);
                        end
                    end else begin
                        chk("idle_lane",
                            int'({rob_told[k], retire_t[k], retire_arch[k]}), 0);
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit [1:0] cv;
        int c0;
        int c1;
        int dn;
        int space;
        dispatch_num   = '0;
        dispatch_t     = '0;
        dispatch_told  = '0;
        dispatch_arch  = '0;
        complete_valid = '0;
        complete_idx   = '0;
`ifdef ROB_FLUSH_EN
        flush = 1'b0;
`endif
        for (int i = 0; i < NW; i++) begin
            lt[i] = 0;
            lo[i] = 0;
            la[i] = 0;
        end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset  = 1'b0;
        active = 1'b1;

        // Idle after reset.
        cycle(0, 2'b00, 0, 0);

        // Dual dispatch, complete both, retire both in order.
        lt[0] = 33; lt[1] = 34;
        lo[0] = 5;  lo[1] = 6;
        la[0] = 3;  la[1] = 4;
        cycle(2, 2'b00, 0, 0);
        cycle(0, 2'b11, 0, 1);
        cycle(0, 2'b00, 0, 0);
        cycle(0, 2'b00, 0, 0);

        // Younger completes first; retirement waits for the older one.
        cycle(2, 2'b00, 0, 0);
        cycle(0, 2'b01, 3, 0);
        cycle(0, 2'b00, 0, 0);
        cycle(0, 2'b01, 2, 0);
        cycle(0, 2'b00, 0, 0);
        cycle(0, 2'b00, 0, 0);

        // Fill to capacity, then an over-full dispatch is dropped.
        repeat (8) begin
            rand_lanes();
            cycle(2, 2'b00, 0, 0);
        end
        rand_lanes();
        cycle(2, 2'b00, 0, 0);
        cycle(0, 2'b00, 0, 0);

        // Drain while refilling so the scan and tail wrap past index 15.
        repeat (14) begin
            rand_lanes();
            comp_oldest(cv, c0, c1);
            space = NR - mq.size();
            dn = (space < 2) ? space : 2;
            cycle(dn, cv, c0, c1);
        end

        // Randomized traffic.
        repeat (400) begin
            rand_lanes();
            space = NR - mq.size();
            dn = int'($urandom_range(0, 2));
            if ($urandom_range(0, 19) != 0 && dn > space) dn = space;
            cv = 2'($urandom_range(0, 3));
            c0 = int'($urandom_range(0, NR - 1));
            c1 = int'($urandom_range(0, NR - 1));
            if (mq.size() > 0 && $urandom_range(0, 9) != 0)
                c0 = mq[$urandom_range(0, mq.size() - 1)].idx;
            if (mq.size() > 0 && $urandom_range(0, 9) != 0)
                c1 = mq[$urandom_range(0, mq.size() - 1)].idx;
            cycle(dn, cv, c0, c1);
        end

        // Drain, bounded.
        for (int n = 0; n < 100 && mq.size() > 0; n++) begin
            comp_oldest(cv, c0, c1);
            cycle(0, cv, c0, c1);
        end
        cycle(0, 2'b00, 0, 0);
        cycle(0, 2'b00, 0, 0);

`ifdef ROB_FLUSH_EN
        // Five live entries, oldest two done; flush suppresses their retire.
        rand_lanes();
        cycle(2, 2'b00, 0, 0);
        rand_lanes();
        cycle(2, 2'b00, 0, 0);
        comp_oldest(cv, c0, c1);
        rand_lanes();
        cycle(1, cv, c0, c1);
        rand_lanes();
        comp_oldest(cv, c0, c1);
        cycle(2, cv, c0, c1, 1'b1);
        cycle(0, 2'b00, 0, 0);
        rand_lanes();
        cycle(2, 2'b00, 0, 0);
        comp_oldest(cv, c0, c1);
        cycle(0, cv, c0, c1);
        cycle(0, 2'b00, 0, 0);
        cycle(0, 2'b00, 0, 0);
`endif

        chk("model_empty", mq.size(), 0);
        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
